cart_loader: RTL and testbench

CART_LOADER -- requirements
Module: cart_loader

---
 rtl/cart_loader_if.sv | 27 ++
 rtl/cart_loader.sv | 215 +++++++++++++++++++++
 tb/tb_cart_loader.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cart_loader_if.sv
// Download byte stream in, target memory write port out.
// The loader is the slave of the ioctl stream and drives the target port.
interface cart_loader_if #(
    parameter int ADDR_W  = 18,
    parameter int NUM_TGT = 2
);
    logic               ioctl_download;
    logic [7:0]         ioctl_index;
    logic [24:0]        ioctl_addr;
    logic [7:0]         ioctl_dout;
    logic               ioctl_wr;
    logic [NUM_TGT-1:0] tgt_we;
    logic [ADDR_W-1:0]  tgt_addr;
    logic [7:0]         tgt_data;

    modport master (
        output ioctl_download, ioctl_index, ioctl_addr,
        output ioctl_dout, ioctl_wr,
        input  tgt_we, tgt_addr, tgt_data
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_addr,
        input  ioctl_dout, ioctl_wr,
        output tgt_we, tgt_addr, tgt_data
    );
endinterface

// File: rtl/cart_loader.sv
// Cartridge/BIOS loader: routes download bytes to a target memory,
// strips an optional 128-byte "ATARI" header and reports cart metadata.
module cart_loader #(
    parameter int ADDR_W  = 18,
    parameter int HDR_LEN = 128,
    parameter int NUM_TGT = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    cart_loader_if.slave bus,
    output logic        hdr_valid,
    output logic [15:0] cart_flags,
    output logic [7:0]  cart_region,
    output logic [31:0] cart_size,
    output logic        load_done,
    output logic        busy,
    output logic        ovf,
    output logic        boot_hold
);
    localparam int SEL_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
    localparam logic [24:0] HDR_END = 25'(HDR_LEN);
    localparam logic [39:0] MAGIC = "ATARI";

    typedef enum logic [2:0] {
        WAIT_LOW,
        IDLE,
        HDR,
        DATA,
        FINISH
    } state_e;

    state_e             state_q, state_d;
    logic               dl_q;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               hv_q, hv_d;
    logic               mism_q, mism_d;
    logic [24:0]        last_q, last_d;
    logic               seen_q, seen_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        flags_q, flags_d;
    logic [7:0]         region_q, region_d;
    logic [31:0]        size_q, size_d;
    logic               boot_q = 1'b1;
    logic               boot_d;
    logic [NUM_TGT-1:0] we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         data_q, data_d;

    logic        rise, fall, stb, is_hdr, in_magic, cart, pay_ovf;
    logic [24:0] pay;
    logic [7:0]  magic_b;
    logic [31:0] total, sub;
    logic [NUM_TGT-1:0] onehot;

    assign rise     = bus.ioctl_download & ~dl_q;
    assign fall     = ~bus.ioctl_download & dl_q;
    assign stb      = (state_q == HDR || state_q == DATA)
                    & bus.ioctl_download & bus.ioctl_wr;
    assign is_hdr   = bus.ioctl_addr < HDR_END;
    assign in_magic = (bus.ioctl_addr >= 25'd1)
                    && (bus.ioctl_addr <= 25'd5);
    assign cart     = sel_q != '0;
    assign pay      = hv_q ? bus.ioctl_addr - HDR_END
                           : bus.ioctl_addr;
    assign pay_ovf  = |(pay >> ADDR_W);
    assign onehot   = NUM_TGT'(1) << sel_q;
    assign total    = {7'd0, last_q} + 32'd1;
    assign sub      = hv_q ? 32'(HDR_LEN) : 32'd0;

    always_comb begin
        case (bus.ioctl_addr[2:0])
            3'd1:    magic_b = MAGIC[39:32];
            3'd2:    magic_b = MAGIC[31:24];
            3'd3:    magic_b = MAGIC[23:16];
            3'd4:    magic_b = MAGIC[15:8];
            3'd5:    magic_b = MAGIC[7:0];
            default: magic_b = 8'h00;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        hv_d     = hv_q;
        mism_d   = mism_q;
        last_d   = last_q;
        seen_d   = seen_q;
        ovf_d    = ovf_q;
        flags_d  = flags_q;
        region_d = region_q;
        size_d   = size_q;
        boot_d   = boot_q;
        we_d     = '0;
        addr_d   = addr_q;
        data_d   = data_q;
        unique case (state_q)
            WAIT_LOW: begin
                if (!bus.ioctl_download) state_d = IDLE;
            end
            IDLE: begin
                if (rise) begin
                    state_d = HDR;
                    if (bus.ioctl_index >= 8'(NUM_TGT-1))
                        sel_d = SEL_W'(NUM_TGT-1);
                    else
                        sel_d = SEL_W'(bus.ioctl_index);
                    hv_d   = 1'b0;
                    mism_d = 1'b0;
                    last_d = '0;
                    seen_d = 1'b0;
                    ovf_d  = 1'b0;
                end
            end
            HDR, DATA: begin
                if (fall) begin
                    state_d = FINISH;
                end else if (stb) begin
                    last_d = bus.ioctl_addr;
                    seen_d = 1'b1;
                    data_d = bus.ioctl_dout;
                    if (is_hdr) begin
                        we_d   = onehot;
                        addr_d = ADDR_W'(bus.ioctl_addr);
                    end else begin
                        state_d = DATA;
                        // Out-of-range payload is dropped, not wrapped.
                        if (pay_ovf) begin
                            ovf_d = 1'b1;
                        end else begin
                            we_d   = onehot;
                            addr_d = ADDR_W'(pay);
                        end
                    end
                    if (cart && is_hdr) begin
                        if (in_magic) begin
                            mism_d = mism_q
                                   | (bus.ioctl_dout != magic_b);
                            if (bus.ioctl_addr == 25'd5)
                                hv_d = ~mism_d;
                        end
                        if (bus.ioctl_addr == 25'd53)
                            flags_d[15:8] = bus.ioctl_dout;
                        if (bus.ioctl_addr == 25'd54)
                            flags_d[7:0] = bus.ioctl_dout;
                        if (bus.ioctl_addr == 25'd57)
                            region_d = bus.ioctl_dout;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                if (cart) begin
                    if (!seen_q)
                        size_d = '0;
                    else if (total > sub)
                        size_d = total - sub;
                    else
                        size_d = '0;
                    boot_d = 1'b0;
                end
            end
            default: state_d = WAIT_LOW;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= WAIT_LOW;
            sel_q    <= '0;
            hv_q     <= 1'b0;
            mism_q   <= 1'b0;
            last_q   <= '0;
            seen_q   <= 1'b0;
            ovf_q    <= 1'b0;
            flags_q  <= '0;
            region_q <= '0;
            size_q   <= '0;
            we_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            hv_q     <= hv_d;
            mism_q   <= mism_d;
            last_q   <= last_d;
            seen_q   <= seen_d;
            ovf_q    <= ovf_d;
            flags_q  <= flags_d;
            region_q <= region_d;
            size_q   <= size_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // Edge detector and boot hold deliberately ignore reset.
    always_ff @(posedge clk_sys) begin
        dl_q <= bus.ioctl_download;
        if (!reset) boot_q <= boot_d;
    end

    assign bus.tgt_we   = we_q;
    assign bus.tgt_addr = addr_q;
    assign bus.tgt_data = data_q;
    assign hdr_valid    = hv_q;
    assign cart_flags   = flags_q;
    assign cart_region  = region_q;
    assign cart_size    = size_q;
    assign load_done    = state_q == FINISH;
    assign busy         = (state_q == HDR) || (state_q == DATA);
    assign ovf          = ovf_q;
    assign boot_hold    = boot_q;
endmodule

// File: tb/tb_cart_loader.sv
// Bench for cart_loader: two instances (ADDR_W 18 and 12) share one
// ioctl stream and are checked every cycle against a behavioural model.
module tb_cart_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        dl;
    logic        wr;
    logic [7:0]  idx;
    logic [24:0] a;
    logic [7:0]  d;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cart_loader_if #(.ADDR_W(18), .NUM_TGT(2)) b18 ();
    cart_loader_if #(.ADDR_W(12), .NUM_TGT(2)) b12 ();

    assign b18.ioctl_download = dl;
    assign b18.ioctl_index    = idx;
    assign b18.ioctl_addr     = a;
    assign b18.ioctl_dout     = d;
    assign b18.ioctl_wr       = wr;
    assign b12.ioctl_download = dl;
    assign b12.ioctl_index    = idx;
    assign b12.ioctl_addr     = a;
    assign b12.ioctl_dout     = d;
    assign b12.ioctl_wr       = wr;

    logic        hv18, hv12, ld18, ld12, bz18, bz12;
    logic        ov18, ov12, bh18, bh12;
    logic [15:0] fl18, fl12;
    logic [7:0]  rg18, rg12;
    logic [31:0] sz18, sz12;

    cart_loader #(.ADDR_W(18), .HDR_LEN(128), .NUM_TGT(2)) u18 (
        .clk_sys(clk), .reset(rst), .bus(b18),
        .hdr_valid(hv18), .cart_flags(fl18), .cart_region(rg18),
        .cart_size(sz18), .load_done(ld18), .busy(bz18),
        .ovf(ov18), .boot_hold(bh18)
    );

    cart_loader #(.ADDR_W(12), .HDR_LEN(128), .NUM_TGT(2)) u12 (
        .clk_sys(clk), .reset(rst), .bus(b12),
        .hdr_valid(hv12), .cart_flags(fl12), .cart_region(rg12),
        .cart_size(sz12), .load_done(ld12), .busy(bz12),
        .ovf(ov12), .boot_hold(bh12)
    );

    // Reference model state
    int         aw[2] = '{18, 12};
    logic       m_wait = 1'b1;
    logic       m_act = 1'b0;
    logic       m_prev = 1'b0;
    int         m_sel = 0;
    logic       m_hv = 1'b0;
    int         m_last = 0;
    logic       m_seen = 1'b0;
    logic       m_ovf[2] = '{1'b0, 1'b0};
    logic [15:0] m_flags = '0;
    logic [7:0] m_region = '0;
    int         m_size = 0;
    logic       m_boot = 1'b1;
    logic [7:0] hdr[128];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic dl_i, input logic wr_i,
                        input int a_i, input logic [7:0] d_i,
                        input logic rst_i);
        int   ew[2];
        int   ea[2];
        int   p;
        logic ed;
        dl  = dl_i;
        wr  = wr_i;
        a   = 25'(a_i);
        d   = d_i;
        rst = rst_i;
        ew  = '{0, 0};
        ea  = '{0, 0};
        ed  = 1'b0;
        if (rst_i) begin
            m_wait = 1'b1; m_act = 1'b0; m_hv = 1'b0;
            m_flags = '0; m_region = '0; m_size = 0;
            m_ovf = '{1'b0, 1'b0};
        end else if (m_wait) begin
            if (!dl_i) m_wait = 1'b0;
        end else if (!m_act) begin
            if (dl_i && !m_prev) begin
                m_act = 1'b1;
                m_sel = (idx >= 1) ? 1 : 0;
                m_hv = 1'b0; m_last = 0; m_seen = 1'b0;
                m_ovf = '{1'b0, 1'b0};
                foreach (hdr[i]) hdr[i] = 8'h00;
            end
        end else if (!dl_i) begin
            ed = 1'b1;
            m_act = 1'b0;
            if (m_sel != 0) begin
                if (!m_seen) m_size = 0;
                else m_size = (m_last + 1 > (m_hv ? 128 : 0))
                            ? m_last + 1 - (m_hv ? 128 : 0) : 0;
                m_boot = 1'b0;
            end
        end else if (wr_i) begin
            m_last = a_i;
            m_seen = 1'b1;
            for (int k = 0; k < 2; k++) begin
                if (a_i < 128) begin
                    ew[k] = 1 << m_sel;
                    ea[k] = a_i % (1 << aw[k]);
                end else begin
                    p = m_hv ? a_i - 128 : a_i;
                    if (p >= (1 << aw[k])) m_ovf[k] = 1'b1;
                    else begin
                        ew[k] = 1 << m_sel;
                        ea[k] = p;
                    end
                end
            end
            if (m_sel != 0 && a_i < 128) begin
                hdr[a_i] = d_i;
                if (a_i == 5)
                    m_hv = {hdr[1], hdr[2], hdr[3], hdr[4], hdr[5]}
                           == 40'h4154415249;
                if (a_i == 53) m_flags[15:8] = d_i;
                if (a_i == 54) m_flags[7:0] = d_i;
                if (a_i == 57) m_region = d_i;
            end
        end
        m_prev = dl_i;
        @(posedge clk);
        #1;
        chk("we18", 32'(b18.tgt_we), ew[0]);
        chk("we12", 32'(b12.tgt_we), ew[1]);
        if (ew[0] != 0) begin
            chk("addr18", 32'(b18.tgt_addr), ea[0]);
            chk("data18", 32'(b18.tgt_data), 32'(d_i));
        end
        if (ew[1] != 0) begin
            chk("addr12", 32'(b12.tgt_addr), ea[1]);
            chk("data12", 32'(b12.tgt_data), 32'(d_i));
        end
        chk("done18", 32'(ld18), 32'(ed));
        chk("done12", 32'(ld12), 32'(ed));
        chk("busy18", 32'(bz18), 32'(m_act));
        chk("busy12", 32'(bz12), 32'(m_act));
        chk("hv18", 32'(hv18), 32'(m_hv));
        chk("hv12", 32'(hv12), 32'(m_hv));
        chk("ovf18", 32'(ov18), 32'(m_ovf[0]));
        chk("ovf12", 32'(ov12), 32'(m_ovf[1]));
    endtask

    // kind: 0 random, 1 ATARI header, 2 headerless (byte 1 != 'A')
    task automatic load(input int index, input int n, input int kind,
                        input int rst_at);
        logic [7:0] b;
        idx = 8'(index);
        step(1'b0, 1'b0, 0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 0, 8'h00, 1'b0);
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (kind == 1) begin
                case (i)
                    1:  b = 8'h41;
                    2:  b = 8'h54;
                    3:  b = 8'h41;
                    4:  b = 8'h52;
                    5:  b = 8'h49;
                    53: b = 8'h00;
                    54: b = 8'h02;
                    57: b = 8'h01;
                    default: ;
                endcase
            end
            if (kind == 2 && i == 1 && b == 8'h41) b = 8'h42;
            if (kind != 1 && $urandom_range(7) == 0)
                step(1'b1, 1'b0, 0, 8'h00, 1'b0);
            step(1'b1, 1'b1, i, b, i == rst_at);
        end
        step(1'b1, 1'b0, 0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 0, 8'h00, 1'b0);
    endtask

    task automatic status(input string tag);
        chk({tag, "_size18"}, sz18, 32'(m_size));
        chk({tag, "_size12"}, sz12, 32'(m_size));
        chk({tag, "_flags"}, 32'(fl18), 32'(m_flags));
        chk({tag, "_region"}, 32'(rg18), 32'(m_region));
        chk({tag, "_boot18"}, 32'(bh18), 32'(m_boot));
        chk({tag, "_boot12"}, 32'(bh12), 32'(m_boot));
    endtask

    initial begin
        idx = 8'd0;
        step(1'b0, 1'b0, 0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 0, 8'h00, 1'b1);
        chk("rst_addr", 32'(b18.tgt_addr), 0);
        chk("rst_data", 32'(b18.tgt_data), 0);
        chk("rst_flags", 32'(fl18), 0);
        chk("rst_region", 32'(rg18), 0);
        chk("rst_size", sz18, 0);
        chk("rst_boot", 32'(bh18), 1);

        load(0, 4096, 0, -1);
        status("bios");
        chk("bios_size", sz18, 0);
        chk("bios_boot", 32'(bh18), 1);

        load(1, 128 + 49152, 1, -1);
        status("hdr");
        chk("hdr_hv", 32'(hv18), 1);
        chk("hdr_size", sz18, 49152);
        chk("hdr_flags", 32'(fl18), 32'h0002);
        chk("hdr_region", 32'(rg18), 1);
        chk("hdr_boot", 32'(bh18), 0);
        chk("hdr_ovf12", 32'(ov12), 1);

        load(2, 4096, 2, -1);
        status("raw");
        chk("raw_hv", 32'(hv18), 0);
        chk("raw_size", sz18, 4096);

        load(1, 2000, 0, 1000);
        status("rstmid");
        chk("rstmid_boot", 32'(bh18), 0);

        load(1, 5000, 2, -1);
        status("big");
        chk("big_size12", sz12, 5000);
        chk("big_ovf12", 32'(ov12), 1);
        chk("big_ovf18", 32'(ov18), 0);

        load(1, 0, 0, -1);
        status("empty");
        chk("empty_size", sz18, 0);

        load(1, 300, 1, -1);
        status("short");
        chk("short_size", sz18, 172);

        load(1, 100, 1, -1);
        status("sat");
        chk("sat_size", sz18, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
